// File: rtl/aes_seq_trigger.sv
// Multi-stage masked sequence trigger on the AES round-state bus.
// Optional inter-stage idle timeout is compiled in with `define TRIG_TIMEOUT_EN.
module aes_seq_trigger #(
    parameter  int DATA_W    = 128,
    parameter  int STAGES    = 4,
    parameter  int STRICT    = 0,
    parameter  int TIMEOUT_W = 16,
    localparam int IDX_W     = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int PROG_W    = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 state_valid,
    input  logic [DATA_W-1:0]    state,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [DATA_W-1:0]    cfg_pattern,
    input  logic [DATA_W-1:0]    cfg_mask,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [PROG_W-1:0]    progress,
    output logic                 tj_trig,
    output logic                 trig_pulse
);

    logic [DATA_W-1:0] r_pattern [STAGES];
    logic [DATA_W-1:0] r_mask    [STAGES];
    logic [PROG_W-1:0] r_prog;
    logic              r_trig;
    logic              r_pulse;

    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_hit0;
    logic              w_active;
    logic              w_expire;
    logic              w_advance;
    logic [PROG_W-1:0] w_prog_nxt;
    logic              w_trig_nxt;
    logic              w_pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_pattern[i] <= '0;
                r_mask[i]    <= '1;
            end
        end else if (cfg_we && (int'(cfg_idx) < STAGES)) begin
            r_pattern[cfg_idx] <= cfg_pattern;
            r_mask[cfg_idx]    <= cfg_mask;
        end
    end

    // Progress reaches STAGES only once triggered; the index is then unused.
    assign w_idx    = (r_prog < PROG_W'(STAGES)) ? r_prog[IDX_W-1:0] : '0;
    assign w_hit    = ((state ^ r_pattern[w_idx]) & r_mask[w_idx]) == '0;
    assign w_hit0   = ((state ^ r_pattern[0]) & r_mask[0]) == '0;
    assign w_active = enable & state_valid & ~r_trig;

`ifdef TRIG_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_idle;
    logic                 w_mid;

    assign w_mid    = (r_prog != '0) && (r_prog != PROG_W'(STAGES));
    assign w_expire = w_mid && (timeout_cycles != '0) && (r_idle == timeout_cycles);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idle <= '0;
        else if (clear || w_advance || w_expire || !w_mid)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^timeout_cycles;
    assign w_expire         = 1'b0;
`endif

    always_comb begin
        w_prog_nxt  = r_prog;
        w_trig_nxt  = r_trig;
        w_pulse_nxt = 1'b0;
        w_advance   = 1'b0;
        if (clear) begin
            w_prog_nxt = '0;
            w_trig_nxt = 1'b0;
        end else if (w_active && w_hit) begin
            w_prog_nxt = r_prog + 1'b1;
            w_advance  = 1'b1;
            if (r_prog == PROG_W'(STAGES - 1)) begin
                w_trig_nxt  = 1'b1;
                w_pulse_nxt = 1'b1;
            end
        end else if ((STRICT != 0) && w_active) begin
            // Strict restart: the failing sample may itself open a new sequence.
            w_prog_nxt = w_hit0 ? PROG_W'(1) : '0;
            w_advance  = w_hit0;
        end else if (w_expire) begin
            w_prog_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog  <= '0;
            r_trig  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prog  <= w_prog_nxt;
            r_trig  <= w_trig_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign progress   = r_prog;
    assign tj_trig    = r_trig;
    assign trig_pulse = r_pulse;

endmodule
